text_write_arbiter: RTL and testbench
=====================================

TEXT_WRITE_ARBITER -- requirements
Module: text_write_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_REQ, 4, number of requesters
- MAX_LEN, 16, maximum characters per transaction
- ROWS, 64, text buffer rows
- COLS, 80, text buffer columns
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock domain
- rst_n, in, 1, asynchronous active-low reset
- req, in, NUM_REQ, per-requester write request (level)
- row, in, NUM_REQ x clog2(ROWS), start row per requester
- col, in, NUM_REQ x clog2(COLS), start column per requester
- len, in, NUM_REQ x clog2(MAX_LEN+1), character count per requester
- data, in, NUM_REQ x MAX_LEN x 8, characters; char k = data[i][8k+:8]
- gnt, out, NUM_REQ, one-hot one-cycle pulse: descriptor i latched
- done, out, NUM_REQ, one-hot one-cycle pulse: transaction i finished
- busy, out, 1, high while not IDLE
- wr_en, out, 1, text buffer write strobe
- wr_row, out, clog2(ROWS), write row
- wr_col, out, clog2(COLS), write column
- wr_char, out, 8, write character

Function
REQ-003 States SHALL be IDLE and WRITE; all outputs SHALL be registered.
REQ-004 In IDLE with any req high, the block SHALL pick one requester round-robin, starting at the index after the last granted one.
REQ-005 On the picking edge, the block SHALL latch row, col, len and data, pulse gnt[i] for one cycle, and enter WRITE.
REQ-006 A requester dropping req or changing its inputs after gnt SHALL NOT affect the latched transaction.
REQ-007 In WRITE, character k SHALL be emitted on the (k+1)th edge after gnt, one per cycle: wr_row=row, wr_col=col+k, wr_char=char k, wr_en=1.
REQ-008 A len greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-009 Characters with col+k >= COLS SHALL be clipped: no wr_en, but the cycle is still consumed (no wrap to the next row).
REQ-010 If row >= ROWS, all writes SHALL be suppressed while timing and done are unchanged.
REQ-011 done[i] SHALL pulse on the same cycle as the final character slot; the state SHALL return to IDLE on the next edge.
REQ-012 If len = 0, done[i] SHALL pulse on the edge after gnt with no wr_en.
REQ-013 Consecutive transactions SHALL be separated by exactly one IDLE cycle, so each transaction occupies len+2 cycles.
REQ-014 A req arriving during WRITE SHALL wait; there SHALL be no preemption.
REQ-015 wr_row, wr_col and wr_char SHALL hold their last value when wr_en=0.
REQ-016 Column arithmetic SHALL be done one bit wider than clog2(COLS) so that the clip compare never wraps.

Reset
REQ-017 While rst_n=0, the block SHALL be asynchronously in IDLE with all outputs at 0 and the round-robin pointer set so requester 0 has highest priority.
REQ-018 Reset asserted mid-WRITE SHALL abort the transaction with no done pulse; the requester SHALL re-request.

Structure
REQ-019 Package text_pkg SHALL hold ROWS, COLS, MAX_LEN, the char_t byte type, and the text_desc_t struct {row, col, len, data}.
REQ-020 Round-robin selection SHALL be a sub-module rr_arbiter (req vector and pointer in, one-hot grant and valid out, combinational).
REQ-021 The rest of the block SHALL be one FSM with a character counter of width clog2(MAX_LEN+1).

Verification
REQ-022 Single request: req[0]=1, row=4, col=55, len=2, data="A1" -> gnt[0] at t+1; writes (4,55,'A') then (4,56,'1'); done[0] with the second write; busy low after.
REQ-023 Contention: req=4'b1111 held, len=1 each, after reset -> grant order 0,1,2,3,0; gnts exactly 3 cycles apart.
REQ-024 Clipping: col=78, len=5 -> writes only at cols 78 and 79; done on the 5th slot.
REQ-025 Boundaries: len=0 -> gnt then done next cycle, no wr_en; len=20 -> exactly 16 slots; row=64 -> no wr_en, done still pulses.
REQ-026 Reset mid-op: rst_n low during the 3rd character of len=8 -> outputs 0 immediately, no done; after release, re-requesting rewrites all 8 characters.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: shared types and default geometry for the text-write path.
//   ROWS, COLS, MAX_LEN : default text buffer geometry and transaction length
//   char_t              : one character byte
//   text_desc_t         : write descriptor {row, col, len, data}; char k = data[k]
package text_pkg;

  localparam int unsigned ROWS    = 64;
  localparam int unsigned COLS    = 80;
  localparam int unsigned MAX_LEN = 16;

  typedef logic [7:0] char_t;

  typedef struct packed {
    logic [$clog2(ROWS)-1:0]      row;
    logic [$clog2(COLS)-1:0]      col;
    logic [$clog2(MAX_LEN+1)-1:0] len;
    char_t [MAX_LEN-1:0]          data;
  } text_desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req   : request vector
//   ptr   : index of the requester with highest priority this round
//   gnt   : one-hot grant (all zero when no request)
//   valid : at least one request present
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // Requests at or above ptr take precedence; if none, wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    gnt    = pick & (~pick + N'(1));
    valid  = |req;
  end

endmodule

// File: rtl/text_write_arbiter.sv
// text_write_arbiter: arbitrates character-string writes from NUM_REQ requesters
// into a ROWS x COLS text buffer, emitting one character per cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req               : per-requester write request (level)
//   row, col, len     : per-requester start row, start column, character count
//   data              : per-requester characters, char k = data[i][8k+:8]
//   gnt               : one-cycle one-hot pulse when a descriptor is latched
//   done              : one-cycle one-hot pulse on the final character slot
//   busy              : high while a transaction is in progress
//   wr_en/row/col/char: text buffer write port (address/data hold when wr_en=0)
module text_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_LEN = text_pkg::MAX_LEN,
  parameter int unsigned ROWS    = text_pkg::ROWS,
  parameter int unsigned COLS    = text_pkg::COLS
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ-1:0][$clog2(ROWS)-1:0]      row,
  input  logic [NUM_REQ-1:0][$clog2(COLS)-1:0]      col,
  input  logic [NUM_REQ-1:0][$clog2(MAX_LEN+1)-1:0] len,
  input  logic [NUM_REQ-1:0][MAX_LEN*8-1:0]         data,
  output logic [NUM_REQ-1:0]                       gnt,
  output logic [NUM_REQ-1:0]                       done,
  output logic                                     busy,
  output logic                                     wr_en,
  output logic [$clog2(ROWS)-1:0]                  wr_row,
  output logic [$clog2(COLS)-1:0]                  wr_col,
  output logic [7:0]                               wr_char
);

  import text_pkg::char_t;

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned LW = $clog2(MAX_LEN+1);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [RW:0]   ROW_LIM = (RW+1)'(ROWS);
  localparam logic [CW:0]   COL_LIM = (CW+1)'(COLS);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   rr_gnt;
  logic                 rr_valid;

  logic [PW-1:0]        sel_idx;
  logic [RW-1:0]        sel_row;
  logic [CW-1:0]        sel_col;
  logic [LW-1:0]        sel_len;
  logic [LW-1:0]        sel_len_clamped;
  logic [MAX_LEN*8-1:0] sel_data;

  logic [NUM_REQ-1:0]   owner_q;
  logic [RW-1:0]        row_q;
  logic                 row_ok_q;
  logic [CW:0]          col_cur;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        cnt;
  logic [MAX_LEN*8-1:0] data_q;
  char_t                cur_char;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  always_comb begin
    sel_idx  = '0;
    sel_row  = '0;
    sel_col  = '0;
    sel_len  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) begin
        sel_idx  = PW'(i);
        sel_row  = row[i];
        sel_col  = col[i];
        sel_len  = len[i];
        sel_data = data[i];
      end
    end
    sel_len_clamped = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
  end

  // Latched characters are shifted down one byte per slot, so the current
  // character is always the low byte; the column likewise runs one bit wide.
  assign cur_char = data_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_char  <= '0;
      owner_q  <= '0;
      row_q    <= '0;
      row_ok_q <= 1'b0;
      col_cur  <= '0;
      len_q    <= '0;
      cnt      <= '0;
      data_q   <= '0;
    end else begin
      gnt   <= '0;
      done  <= '0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_valid) begin
            state    <= WRITE;
            busy     <= 1'b1;
            gnt      <= rr_gnt;
            owner_q  <= rr_gnt;
            row_q    <= sel_row;
            row_ok_q <= ({1'b0, sel_row} < ROW_LIM);
            col_cur  <= {1'b0, sel_col};
            len_q    <= sel_len_clamped;
            cnt      <= '0;
            data_q   <= sel_data;
            rr_ptr   <= (sel_idx == PW'(NUM_REQ-1)) ? '0 : sel_idx + PW'(1);
          end
        end
        WRITE: begin
          // The slot after the last character is the mandatory IDLE gap's
          // preceding edge; a zero-length transaction signals done right here.
          if (cnt == len_q) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (len_q == '0) begin
              done <= owner_q;
            end
          end else begin
            cnt     <= cnt + LW'(1);
            col_cur <= col_cur + (CW+1)'(1);
            data_q  <= data_q >> 8;
            if (row_ok_q && (col_cur < COL_LIM)) begin
              wr_en   <= 1'b1;
              wr_row  <= row_q;
              wr_col  <= col_cur[CW-1:0];
              wr_char <= cur_char;
            end
            if (cnt + LW'(1) == len_q) begin
              done <= owner_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_write_arbiter.sv
// tb_text_write_arbiter: directed self-checking bench for text_write_arbiter.
// The DUT runs with ROWS=48 so that an out-of-range row still fits the
// 6-bit row field; all other parameters are the package defaults.
module tb_text_write_arbiter;

  import text_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned TB_ROWS = 48;
  localparam int unsigned RW      = $clog2(TB_ROWS);
  localparam int unsigned CW      = $clog2(COLS);
  localparam int unsigned LW      = $clog2(MAX_LEN+1);

  logic                          clk   = 1'b0;
  logic                          rst_n = 1'b1;
  logic [N-1:0]                  req   = '0;
  logic [N-1:0][RW-1:0]          row   = '0;
  logic [N-1:0][CW-1:0]          col   = '0;
  logic [N-1:0][LW-1:0]          len   = '0;
  logic [N-1:0][MAX_LEN*8-1:0]   data  = '0;
  logic [N-1:0]                  gnt;
  logic [N-1:0]                  done;
  logic                          busy;
  logic                          wr_en;
  logic [RW-1:0]                 wr_row;
  logic [CW-1:0]                 wr_col;
  logic [7:0]                    wr_char;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_cnt  = 0;

  text_write_arbiter #(
    .NUM_REQ (N),
    .MAX_LEN (MAX_LEN),
    .ROWS    (TB_ROWS),
    .COLS    (COLS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .row     (row),
    .col     (col),
    .len     (len),
    .data    (data),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_char (wr_char)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gnt"},     32'(gnt),     32'd0);
    check_eq({tag, "_done"},    32'(done),    32'd0);
    check_eq({tag, "_busy"},    32'(busy),    32'd0);
    check_eq({tag, "_wr_en"},   32'(wr_en),   32'd0);
    check_eq({tag, "_wr_row"},  32'(wr_row),  32'd0);
    check_eq({tag, "_wr_col"},  32'(wr_col),  32'd0);
    check_eq({tag, "_wr_char"}, 32'(wr_char), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_desc(input int unsigned i, input logic [RW-1:0] r, input logic [CW-1:0] c,
                          input logic [LW-1:0] l, input logic [7:0] base);
    text_desc_t d;
    d.row = r;
    d.col = c;
    d.len = l;
    for (int k = 0; k < MAX_LEN; k++) d.data[k] = base + 8'(k);
    row[i]  = d.row;
    col[i]  = d.col;
    len[i]  = d.len;
    data[i] = d.data;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int unsigned waited, output int unsigned stamp);
    g      = '0;
    waited = 0;
    stamp  = 0;
    while (waited < 10) begin
      step();
      waited++;
      if (gnt != '0) begin
        g     = gnt;
        stamp = cyc_cnt;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    int unsigned  waited, stamp, last_stamp, e, nw, dslot;
    last_stamp = 0;

    // Reset state
    #2 rst_n = 1'b0;
    #2 check_idle_outputs("reset");
    do_reset();

    // Single request, inputs disturbed after grant
    set_desc(0, 6'd4, 7'd55, 5'd2, 8'h41);
    data[0][15:8] = 8'h31;
    req = 4'b0001;
    step();
    check_eq("single_gnt",   32'(gnt),   32'h1);
    check_eq("single_busy",  32'(busy),  32'd1);
    check_eq("single_wr_en0", 32'(wr_en), 32'd0);
    req = '0;
    set_desc(0, 6'd9, 7'd0, 5'd7, 8'h70);
    step();
    check_eq("single_c0_en",   32'(wr_en),   32'd1);
    check_eq("single_c0_row",  32'(wr_row),  32'd4);
    check_eq("single_c0_col",  32'(wr_col),  32'd55);
    check_eq("single_c0_char", 32'(wr_char), 32'h41);
    check_eq("single_c0_done", 32'(done),    32'd0);
    step();
    check_eq("single_c1_en",   32'(wr_en),   32'd1);
    check_eq("single_c1_col",  32'(wr_col),  32'd56);
    check_eq("single_c1_char", 32'(wr_char), 32'h31);
    check_eq("single_c1_done", 32'(done),    32'h1);
    step();
    check_eq("single_end_busy", 32'(busy),   32'd0);
    check_eq("single_end_en",   32'(wr_en),  32'd0);
    check_eq("single_end_done", 32'(done),   32'd0);
    check_eq("single_hold_col", 32'(wr_col), 32'd56);

    // Contention, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) set_desc(i, 6'(i + 1), 7'(10 * i), 5'd1, 8'h50 + 8'(i));
    req = '1;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(g, waited, stamp);
      e = t % N;
      check_eq("rr_order", 32'(g), 32'(1) << e);
      if (t == 0) check_eq("rr_first_latency", waited, 32'd1);
      else        check_eq("rr_gap", stamp - last_stamp, 32'd3);
      last_stamp = stamp;
      if (t == 4) req = '0;
      step();
      check_eq("rr_char", 32'(wr_char), 32'h50 + e);
      check_eq("rr_done", 32'(done), 32'(1) << e);
    end
    step();
    check_eq("rr_end_busy", 32'(busy), 32'd0);

    // Column clipping
    set_desc(2, 6'd5, 7'd78, 5'd5, 8'h30);
    req = 4'b0100;
    wait_gnt(g, waited, stamp);
    check_eq("clip_gnt", 32'(g), 32'h4);
    req = '0;
    for (int s = 1; s <= 5; s++) begin
      step();
      check_eq("clip_wr_en", 32'(wr_en), (s <= 2) ? 32'd1 : 32'd0);
      if (s <= 2) begin
        check_eq("clip_col",  32'(wr_col),  32'(77 + s));
        check_eq("clip_char", 32'(wr_char), 32'(8'h30 + s - 1));
      end
      check_eq("clip_done", 32'(done), (s == 5) ? 32'h4 : 32'd0);
    end
    check_eq("clip_hold_col", 32'(wr_col), 32'd79);
    step();
    check_eq("clip_end_busy", 32'(busy), 32'd0);

    // Zero length
    set_desc(1, 6'd2, 7'd3, 5'd0, 8'h20);
    req = 4'b0010;
    wait_gnt(g, waited, stamp);
    check_eq("len0_gnt", 32'(g), 32'h2);
    req = '0;
    step();
    check_eq("len0_done",  32'(done),  32'h2);
    check_eq("len0_wr_en", 32'(wr_en), 32'd0);
    check_eq("len0_busy",  32'(busy),  32'd0);
    step();
    check_eq("len0_done_clear", 32'(done), 32'd0);

    // Over-long length is clamped to MAX_LEN
    set_desc(3, 6'd1, 7'd0, 5'd20, 8'h61);
    req = 4'b1000;
    wait_gnt(g, waited, stamp);
    check_eq("len20_gnt", 32'(g), 32'h8);
    req = '0;
    nw = 0;
    dslot = 0;
    for (int s = 1; s <= 18; s++) begin
      step();
      if (wr_en) begin
        check_eq("len20_char", 32'(wr_char), 32'h61 + nw);
        check_eq("len20_col",  32'(wr_col),  nw);
        nw++;
      end
      if (done != '0) dslot = s;
    end
    check_eq("len20_writes",    nw,         32'd16);
    check_eq("len20_done_slot", dslot,      32'd16);
    check_eq("len20_end_busy",  32'(busy),  32'd0);

    // Out-of-range row: no writes, done timing unchanged
    set_desc(0, 6'd48, 7'd10, 5'd3, 8'h40);
    req = 4'b0001;
    wait_gnt(g, waited, stamp);
    check_eq("badrow_gnt", 32'(g), 32'h1);
    req = '0;
    nw = 0;
    dslot = 0;
    for (int s = 1; s <= 4; s++) begin
      step();
      if (wr_en) nw++;
      if (done != '0) dslot = s;
    end
    check_eq("badrow_writes",    nw,    32'd0);
    check_eq("badrow_done_slot", dslot, 32'd3);

    // Reset during the third character, then full rewrite
    set_desc(1, 6'd10, 7'd0, 5'd8, 8'h41);
    req = 4'b0010;
    wait_gnt(g, waited, stamp);
    check_eq("rst_gnt", 32'(g), 32'h2);
    step();
    step();
    step();
    check_eq("rst_c2_en",   32'(wr_en),   32'd1);
    check_eq("rst_c2_char", 32'(wr_char), 32'h43);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    for (int s = 0; s < 3; s++) begin
      step();
      check_eq("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    wait_gnt(g, waited, stamp);
    check_eq("rst_regnt", 32'(g), 32'h2);
    req = '0;
    for (int s = 0; s < 8; s++) begin
      step();
      check_eq("rst_re_en",   32'(wr_en),   32'd1);
      check_eq("rst_re_char", 32'(wr_char), 32'(8'h41 + s));
      check_eq("rst_re_col",  32'(wr_col),  32'(s));
      check_eq("rst_re_done", 32'(done), (s == 7) ? 32'h2 : 32'd0);
    end
    step();
    check_eq("rst_end_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
